// File: rtl/fractional_add_pkg.sv
// Shared fixed-point definitions for the fractional adder slice.
// Contents:
//   DEFAULT_DATA_WIDTH - full fixed-point word width (Q7.8)
//   FRAC_W             - fractional width, half of the word
//   FRAC_MAX           - all-ones fraction, the saturation value
//   frac_t             - fractional operand type at the default width
package fixed_point_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int FRAC_W = DEFAULT_DATA_WIDTH / 2;
  localparam logic [FRAC_W-1:0] FRAC_MAX = '1;

  typedef logic [FRAC_W-1:0] frac_t;

endpackage

// File: rtl/fractional_add_if.sv
// Operand/result bundle for fractional_add.
// Handshake: the master holds A/B stable with in_valid = 1 for every cycle
// it wants an addition; each such rising clk edge yields exactly one
// result, presented one cycle later with out_valid = 1 for one cycle.
// There is no ready: the slave accepts every cycle.
//   master: drives in_valid, A, B; observes Out, C, Z, out_valid
//   slave : observes in_valid, A, B; drives Out, C, Z, out_valid
interface fractional_add_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int F = DATA_WIDTH / 2;

  logic         in_valid;
  logic [F-1:0] A;
  logic [F-1:0] B;
  logic [F-1:0] Out;
  logic         C;
  logic         Z;
  logic         out_valid;

  modport master (output in_valid, A, B, input Out, C, Z, out_valid);
  modport slave  (input in_valid, A, B, output Out, C, Z, out_valid);

endinterface

// File: rtl/fractional_add_sat_adder.sv
// frac_sat_adder: combinational unsigned fraction adder.
// Ports:
//   a, b  - unsigned fractions (LSB weight 2^-FRAC_W)
//   sum   - result, clamped to all-ones on carry when SATURATE != 0,
//           otherwise wrapped modulo 2^FRAC_W
//   carry - true sum >= 1.0, reported in both modes
module frac_sat_adder #(
  parameter int FRAC_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic [FRAC_W-1:0] a,
  input  logic [FRAC_W-1:0] b,
  output logic [FRAC_W-1:0] sum,
  output logic              carry
);

  logic [FRAC_W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[FRAC_W];
    if ((SATURATE != 0) && raw[FRAC_W]) begin
      sum = '1;
    end else begin
      sum = raw[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fractional_add.sv
// fractional_add: registered saturating/wrapping adder for the fractional
// halves of two fixed-point words, one cycle of latency.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of fractional_add_if (in_valid, A, B in;
//           Out, C, Z, out_valid out)
// Out/C/Z hold their last value on cycles without in_valid; out_valid
// is in_valid delayed by one cycle.
module fractional_add
  import fixed_point_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SATURATE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  fractional_add_if.slave bus
);

  localparam int F = DATA_WIDTH / 2;

  logic [F-1:0] sum;
  logic         carry;

  frac_sat_adder #(
    .FRAC_W   (F),
    .SATURATE (SATURATE)
  ) u_adder (
    .a     (bus.A),
    .b     (bus.B),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Out       <= '0;
      bus.C         <= 1'b0;
      bus.Z         <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Out <= sum;
        bus.C   <= carry;
        // Zero flag follows the post-saturation value.
        bus.Z   <= (sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_fractional_add.sv
// Bench for fractional_add: one saturating and one wrapping instance share
// the same directed stimulus; each has its own expected-result queue.
module tb_fractional_add;

  localparam int DW = 16;
  localparam int F  = DW / 2;

  logic clk;
  logic rst_n;

  fractional_add_if #(.DATA_WIDTH(DW)) bus_s ();
  fractional_add_if #(.DATA_WIDTH(DW)) bus_w ();

  fractional_add #(.DATA_WIDTH(DW), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  fractional_add #(.DATA_WIDTH(DW), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state: entries are {Out, C, Z}
  logic [F+1:0] exp_s[$];
  logic [F+1:0] exp_w[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic send(input logic [F-1:0] a, input logic [F-1:0] b,
                      input logic [F-1:0] out_s, input logic [F-1:0] out_w,
                      input logic c);
    bus_s.in_valid = 1'b1; bus_s.A = a; bus_s.B = b;
    bus_w.in_valid = 1'b1; bus_w.A = a; bus_w.B = b;
    exp_s.push_back({out_s, c, (out_s == '0)});
    exp_w.push_back({out_w, c, (out_w == '0)});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus_s.in_valid = 1'b0;
    bus_w.in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_out"}, 16'(bus_s.Out), 16'h0);
    check({tag, "_s_c"},   16'(bus_s.C), 16'h0);
    check({tag, "_s_z"},   16'(bus_s.Z), 16'h1);
    check({tag, "_s_ov"},  16'(bus_s.out_valid), 16'h0);
    check({tag, "_w_out"}, 16'(bus_w.Out), 16'h0);
    check({tag, "_w_z"},   16'(bus_w.Z), 16'h1);
    check({tag, "_w_ov"},  16'(bus_w.out_valid), 16'h0);
  endtask

  // monitor: pop and compare whenever a result is presented
  always @(negedge clk) begin
    logic [F+1:0] e;
    if (bus_s.out_valid) begin
      if (exp_s.size() == 0) begin
        check("sat_unexpected_valid", 16'h1, 16'h0);
      end else begin
        e = exp_s.pop_front();
        check("sat_out", 16'(bus_s.Out), 16'(e[F+1:2]));
        check("sat_c",   16'(bus_s.C),   16'(e[1]));
        check("sat_z",   16'(bus_s.Z),   16'(e[0]));
      end
    end
    if (bus_w.out_valid) begin
      if (exp_w.size() == 0) begin
        check("wrap_unexpected_valid", 16'h1, 16'h0);
      end else begin
        e = exp_w.pop_front();
        check("wrap_out", 16'(bus_w.Out), 16'(e[F+1:2]));
        check("wrap_c",   16'(bus_w.C),   16'(e[1]));
        check("wrap_z",   16'(bus_w.Z),   16'(e[0]));
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    // reset held with live inputs
    bus_s.in_valid = 1'b1; bus_s.A = 8'h40; bus_s.B = 8'h40;
    bus_w.in_valid = 1'b1; bus_w.A = 8'h40; bus_w.B = 8'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;

    send(8'h40, 8'h40, 8'h80, 8'h80, 1'b0);
    idle();
    @(posedge clk); #1;

    // saturation / wrap boundaries
    send(8'hC0, 8'h80, 8'hFF, 8'h40, 1'b1);
    send(8'h80, 8'h80, 8'hFF, 8'h00, 1'b1);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    send(8'h7F, 8'h80, 8'hFF, 8'hFF, 1'b0);
    send(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    idle();
    repeat (2) @(posedge clk); #1;

    // streaming: out_valid must stay high on consecutive cycles
    send(8'h01, 8'h01, 8'h02, 8'h02, 1'b0);
    send(8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0);
    check("stream_ov_1", 16'(bus_s.out_valid), 16'h1);
    send(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1);
    check("stream_ov_2", 16'(bus_s.out_valid), 16'h1);
    send(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check("stream_ov_3", 16'(bus_s.out_valid), 16'h1);
    idle();
    check("stream_ov_4", 16'(bus_s.out_valid), 16'h1);
    @(posedge clk); #1;

    // hold: outputs keep last value when in_valid is low
    send(8'h10, 8'h20, 8'h30, 8'h30, 1'b0);
    idle();
    bus_s.A = 8'h55; bus_s.B = 8'hEE;
    bus_w.A = 8'h55; bus_w.B = 8'hEE;
    repeat (2) @(posedge clk); #1;
    check("hold_s_out", 16'(bus_s.Out), 16'h30);
    check("hold_s_ov",  16'(bus_s.out_valid), 16'h0);
    check("hold_w_out", 16'(bus_w.Out), 16'h30);
    check("hold_w_c",   16'(bus_w.C), 16'h0);

    // asynchronous reset while a result is on the outputs
    send(8'h33, 8'h44, 8'h77, 8'h77, 1'b0);
    idle();
    check("pre_reset_ov", 16'(bus_s.out_valid), 16'h1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h01, 8'h02, 8'h03, 8'h03, 1'b0);
    idle();
    repeat (3) @(posedge clk); #1;

    check("sat_queue_left",  16'(exp_s.size()), 16'h0);
    check("wrap_queue_left", 16'(exp_w.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
